// File: rtl/poly_tone_engine_if.sv
// Key event channel from the keypad scanner into the tone engine.
// The scanner drives it as master; the engine accepts events as slave.
interface poly_tone_engine_if #(
  parameter int unsigned KEYS = 16
);
  localparam int unsigned CW = (KEYS > 1) ? $clog2(KEYS) : 1;

  logic          key_valid;
  logic [CW-1:0] key_code;
  logic          key_on;
  logic          key_ready;

  modport master (output key_valid, key_code, key_on, input key_ready);
  modport slave  (input key_valid, key_code, key_on, output key_ready);
endinterface

// File: rtl/poly_tone_engine.sv
// Polyphonic square-wave tone engine: LRU voice allocation with retrigger and auto-release,
// and a PWM mixer that drives a single-bit sound output.
module poly_tone_engine #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned VOICES   = 4,
  parameter int unsigned KEYS     = 16,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned HOLD_CYC = 0
) (
  input  logic                clk,
  input  logic                clear_n,
  poly_tone_engine_if.slave   kbus,
  output logic [VOICES-1:0]   voice_active,
  output logic                sound
);

  // Half period in clock cycles for key k, rounded to nearest.
  function automatic int unsigned half_of(int unsigned k);
    real f;
    f = 261.63 * (2.0 ** (real'(k) / 12.0));
    return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
  endfunction

  localparam int unsigned KW  = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int unsigned NK  = 2 ** KW;
  localparam int unsigned RW  = $clog2(VOICES);
  localparam int unsigned HW  = $clog2(VOICES + 1);
  localparam int unsigned CW  = $clog2(half_of(0) + 1);
  localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {StIdle, StAlloc} state_e;

  logic [CW-1:0] half_tab [NK];
  logic [NK-1:0] key_ok;

  for (genvar k = 0; k < NK; k++) begin : g_key
    localparam int unsigned H = half_of(k);
    assign half_tab[k] = CW'(H);
    assign key_ok[k]   = (k < KEYS);
  end

  state_e              state_q, state_d;
  logic [KW-1:0]       ev_code_q;
  logic                ev_on_q;
  logic [VOICES-1:0]   active_q, active_d;
  logic [VOICES-1:0]   tone_q, tone_d;
  logic [KW-1:0]       vkey_q  [VOICES];
  logic [KW-1:0]       vkey_d  [VOICES];
  logic [RW-1:0]       rank_q  [VOICES];
  logic [RW-1:0]       rank_d  [VOICES];
  logic [CW-1:0]       phase_q [VOICES];
  logic [CW-1:0]       phase_d [VOICES];
  logic [HCW-1:0]      hold_q  [VOICES];
  logic [HCW-1:0]      hold_d  [VOICES];
  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS:0]   thr_q, thr_new, thr_eff;
  logic [HW-1:0]       h;

  logic          hit, free_ok;
  logic [RW-1:0] hit_v, free_v, old_v, tgt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (kbus.key_valid) state_d = StAlloc;
      StAlloc: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hit     = 1'b0;
    hit_v   = '0;
    free_ok = 1'b0;
    free_v  = '0;
    old_v   = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (active_q[v] && vkey_q[v] == ev_code_q) begin
        hit   = 1'b1;
        hit_v = RW'(v);
      end
      if (rank_q[v] == RW'(VOICES - 1)) old_v = RW'(v);
    end
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (!active_q[v]) begin
        free_ok = 1'b1;
        free_v  = RW'(v);
      end
    end
    tgt = hit ? hit_v : (free_ok ? free_v : old_v);
  end

  always_comb begin
    active_d = active_q;
    tone_d   = tone_q;
    vkey_d   = vkey_q;
    rank_d   = rank_q;
    phase_d  = phase_q;
    hold_d   = hold_q;
    for (int v = 0; v < VOICES; v++) begin
      if (!active_q[v]) begin
        phase_d[v] = '0;
        tone_d[v]  = 1'b0;
        hold_d[v]  = '0;
      end else begin
        if (phase_q[v] == half_tab[vkey_q[v]] - CW'(1)) begin
          phase_d[v] = '0;
          tone_d[v]  = ~tone_q[v];
        end else begin
          phase_d[v] = phase_q[v] + CW'(1);
        end
        if (HOLD_CYC != 0) begin
          if (hold_q[v] == HCW'(HOLD_CYC - 1)) begin
            active_d[v] = 1'b0;
            phase_d[v]  = '0;
            tone_d[v]   = 1'b0;
            hold_d[v]   = '0;
          end else begin
            hold_d[v] = hold_q[v] + HCW'(1);
          end
        end
      end
    end
    // Commit is applied last so it overrides a same-cycle auto-release.
    if (state_q == StAlloc && key_ok[ev_code_q]) begin
      if (ev_on_q) begin
        active_d[tgt] = 1'b1;
        vkey_d[tgt]   = ev_code_q;
        phase_d[tgt]  = '0;
        tone_d[tgt]   = 1'b0;
        hold_d[tgt]   = '0;
        for (int v = 0; v < VOICES; v++) begin
          if (RW'(v) == tgt) begin
            rank_d[v] = '0;
          end else if (rank_q[v] < rank_q[tgt]) begin
            rank_d[v] = rank_q[v] + RW'(1);
          end
        end
      end else if (hit) begin
        active_d[hit_v] = 1'b0;
        phase_d[hit_v]  = '0;
        tone_d[hit_v]   = 1'b0;
        hold_d[hit_v]   = '0;
      end
    end
  end

  always_comb begin
    h = '0;
    for (int v = 0; v < VOICES; v++) h = h + HW'(active_q[v] & tone_q[v]);
    thr_new = (PWM_BITS + 1)'(h) << (PWM_BITS - RW);
    thr_eff = (pwm_q == '0) ? thr_new : thr_q;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= StIdle;
      ev_code_q <= '0;
      ev_on_q   <= 1'b0;
      active_q  <= '0;
      tone_q    <= '0;
      pwm_q     <= '0;
      thr_q     <= '0;
      for (int v = 0; v < VOICES; v++) begin
        vkey_q[v]  <= '0;
        rank_q[v]  <= RW'(v);
        phase_q[v] <= '0;
        hold_q[v]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && kbus.key_valid) begin
        ev_code_q <= kbus.key_code;
        ev_on_q   <= kbus.key_on;
      end
      active_q <= active_d;
      tone_q   <= tone_d;
      vkey_q   <= vkey_d;
      rank_q   <= rank_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      pwm_q    <= pwm_q + PWM_BITS'(1);
      thr_q    <= thr_eff;
    end
  end

  assign kbus.key_ready = clear_n && (state_q == StIdle);
  assign voice_active   = active_q;
  assign sound          = (|active_q) && ({1'b0, pwm_q} < thr_eff);

endmodule

// File: tb/tb_poly_tone_engine.sv
// Randomised and directed bench for poly_tone_engine against a timestamp-based voice model.
module tb_poly_tone_engine;
  localparam int unsigned CLKHZ = 250_000;
  localparam int V    = 4;
  localparam int K    = 12;
  localparam int PB   = 8;
  localparam int HOLD = 1000;
  localparam int FR   = 2 ** PB;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic [V-1:0] voice_active;
  logic         sound;

  poly_tone_engine_if #(.KEYS(K)) kb ();

  poly_tone_engine #(
    .CLK_HZ(CLKHZ), .VOICES(V), .KEYS(K), .PWM_BITS(PB), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .clear_n(clear_n), .kbus(kb), .voice_active(voice_active), .sound(sound)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each voice remembers its key and the first cycle after its commit; tone and
  // auto-release follow from elapsed time. LRU is a queue, most recent at the front.
  int     half_tab [16];
  bit     mon [V];
  int     mkey [V];
  longint mt0 [V];
  int     order [$];
  bit     pend, pend_on;
  int     pend_code;
  longint n;
  int     thr, frame_ones, last_duty, last_thr;

  initial begin
    for (int k = 0; k < 16; k++)
      half_tab[k] = $rtoi(real'(CLKHZ) / (2.0 * 261.63 * (2.0 ** (real'(k) / 12.0))) + 0.5);
  end

  function automatic bit act(int v, longint t);
    return mon[v] && (HOLD == 0 || (t - mt0[v]) < HOLD);
  endfunction

  function automatic bit tone(int v, longint t);
    return act(v, t) && (((t - mt0[v]) / half_tab[mkey[v]]) % 2 == 1);
  endfunction

  function automatic int owner(int code);
    for (int v = 0; v < V; v++) if (mon[v] && mkey[v] == code) return v;
    return -1;
  endfunction

  task automatic model_reset();
    order.delete();
    for (int v = 0; v < V; v++) begin
      mon[v] = 0; mkey[v] = 0; mt0[v] = 0;
      order.push_back(v);
    end
    pend = 0; n = 0; thr = 0; frame_ones = 0;
  endtask

  task automatic apply(int code, bit on, longint t);
    int hit = -1;
    int tgt = -1;
    if (code >= K) return;
    for (int v = 0; v < V; v++) if (act(v, t) && mkey[v] == code) hit = v;
    if (!on) begin
      if (hit >= 0) mon[hit] = 0;
      return;
    end
    tgt = hit;
    if (tgt < 0) for (int v = V - 1; v >= 0; v--) if (!act(v, t)) tgt = v;
    if (tgt < 0) tgt = order[$];
    mon[tgt] = 1; mkey[tgt] = code; mt0[tgt] = t + 1;
    for (int i = 0; i < order.size(); i++) if (order[i] == tgt) begin
      order.delete(i);
      break;
    end
    order.push_front(tgt);
  endtask

  always @(negedge clk) begin : cmp
    logic [V-1:0] ea;
    int h;
    bit es;
    if (!clear_n) begin
      chk("rst_ready", kb.key_ready, 0);
      chk("rst_active", voice_active, 0);
      chk("rst_sound", sound, 0);
      model_reset();
    end else begin
      h = 0;
      ea = '0;
      for (int v = 0; v < V; v++) begin
        ea[v] = act(v, n);
        if (tone(v, n)) h++;
      end
      if (n % FR == 0) begin
        thr = h * FR / V;
        frame_ones = 0;
      end
      es = (ea != 0) && ((n % FR) < thr);
      chk("key_ready", kb.key_ready, !pend);
      chk("voice_active", voice_active, ea);
      chk("sound", sound, es);
      frame_ones += int'(sound);
      if (n % FR == FR - 1) begin
        last_duty = frame_ones;
        last_thr  = thr;
      end
      if (pend) begin
        apply(pend_code, pend_on, n);
        pend = 0;
      end else if (kb.key_valid) begin
        pend = 1; pend_code = int'(kb.key_code); pend_on = kb.key_on;
      end
      n++;
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(int code, bit on);
    int w = 0;
    kb.key_valid = 1'b1; kb.key_code = 4'(code); kb.key_on = on;
    @(negedge clk);
    while (!kb.key_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!kb.key_ready) chk("send_ready", kb.key_ready, 1);
    @(posedge clk);
    #1 kb.key_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    tick(3);
    clear_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    kb.key_valid = 1'b0; kb.key_code = '0; kb.key_on = 1'b0;
    repeat (5) @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", kb.key_ready, 1);
    chk("post_rst_active", voice_active, 0);
    chk("post_rst_sound", sound, 0);
    chk("half_key0", half_tab[0], 478);
    chk("half_key9", half_tab[9], 284);

    send(9, 1);
    chk("note9_active", voice_active, 4'b0001);
    tick(50);
    send(9, 0);
    chk("note9_off", voice_active, 4'b0000);
    chk("note9_sound", sound, 0);

    send(0, 1); send(4, 1); send(7, 1);
    chk("chord_active", voice_active, 4'b0111);
    tick(700);
    chk("chord_duty", last_duty, last_thr);
    chk("chord_duty_max", last_duty <= 192, 1);
    chk("chord_duty_step", last_duty % 64, 0);

    do_reset();
    send(0, 1); send(1, 1); send(2, 1); send(3, 1);
    chk("four_active", voice_active, 4'b1111);
    send(5, 1);
    chk("steal5_voice", owner(5), 0);
    send(6, 1);
    chk("steal6_voice", owner(6), 1);
    chk("steal_active", voice_active, 4'b1111);

    do_reset();
    send(2, 1);
    tick(10);
    send(2, 1);
    chk("retrig_active", voice_active, 4'b0001);
    chk("retrig_voice", owner(2), 0);
    send(11, 0);
    chk("release_idle_key", voice_active, 4'b0001);
    send(13, 1);
    chk("bad_key_press", voice_active, 4'b0001);
    send(14, 0);
    chk("bad_key_release", voice_active, 4'b0001);

    do_reset();
    send(3, 1);
    tick(HOLD - 1);
    chk("hold_last_cycle", voice_active, 4'b0001);
    tick(1);
    chk("hold_expired", voice_active, 4'b0000);

    kb.key_valid = 1'b1; kb.key_code = 4'd4; kb.key_on = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 kb.key_valid = 1'b0;
    clear_n = 1'b0;
    tick(3);
    clear_n = 1'b1;
    tick(2);
    chk("rst_mid_alloc", voice_active, 4'b0000);

    // Dense phase exercises allocation; sparse phase lets tones develop for the mixer.
    for (int i = 0; i < 1500; i++) begin
      kb.key_valid = ($urandom_range(0, 2) == 0);
      kb.key_code  = 4'($urandom_range(0, 13));
      kb.key_on    = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    for (int i = 0; i < 4000; i++) begin
      kb.key_valid = ($urandom_range(0, 119) == 0);
      kb.key_code  = 4'($urandom_range(0, 13));
      kb.key_on    = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    kb.key_valid = 1'b0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
